// File: rtl/tdm_demux4.sv
// Receive-side TDM demultiplexer: locks to a start-of-frame marker, gathers four
// slot beats into shadows and publishes all channels together once per frame.
module tdm_demux4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_vld,
    input  logic         sof,
    output logic [W-1:0] ch0,
    output logic [W-1:0] ch1,
    output logic [W-1:0] ch2,
    output logic [W-1:0] ch3,
    output logic         frame_vld,
    output logic         sync_err,
    output logic         locked,
    output logic [7:0]   frame_cnt
);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t       state_q, state_d;
    logic [1:0]   slot_q, slot_d;
    logic [W-1:0] sh0, sh1, sh2;
    logic         sh_wr;
    logic [1:0]   sh_sel;
    logic         publish;
    logic         err;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sh_wr   = 1'b0;
        sh_sel  = slot_q;
        publish = 1'b0;
        err     = 1'b0;
        if (din_vld) begin
            case (state_q)
                HUNT: begin
                    if (sof) begin
                        sh_wr   = 1'b1;
                        sh_sel  = 2'd0;
                        slot_d  = 2'd1;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (sof) begin
                        // A marker mid-frame drops the partial frame and restarts at slot 0.
                        sh_wr  = 1'b1;
                        sh_sel = 2'd0;
                        slot_d = 2'd1;
                        err    = (slot_q != 2'd0);
                    end else if (slot_q == 2'd0) begin
                        err     = 1'b1;
                        state_d = HUNT;
                    end else if (slot_q == 2'd3) begin
                        publish = 1'b1;
                        slot_d  = 2'd0;
                    end else begin
                        sh_wr  = 1'b1;
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            slot_q    <= 2'd0;
            sh0       <= '0;
            sh1       <= '0;
            sh2       <= '0;
            ch0       <= '0;
            ch1       <= '0;
            ch2       <= '0;
            ch3       <= '0;
            frame_vld <= 1'b0;
            sync_err  <= 1'b0;
            locked    <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            frame_vld <= publish;
            sync_err  <= err;
            locked    <= (state_d == LOCK);
            if (sh_wr) begin
                case (sh_sel)
                    2'd0:    sh0 <= din;
                    2'd1:    sh1 <= din;
                    2'd2:    sh2 <= din;
                    default: ;
                endcase
            end
            if (publish) begin
                ch0       <= sh0;
                ch1       <= sh1;
                ch2       <= sh2;
                ch3       <= din;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized bench for tdm_demux4 against a queue-based frame reassembly model.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_vld;
    logic       sof;
    logic [3:0] ch0, ch1, ch2, ch3;
    logic       frame_vld, sync_err, locked;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] q[$];
    bit         m_lock;
    logic [3:0] m_ch[4];
    bit         m_fv, m_se;
    int         m_cnt;
    int         fv_seen;

    tdm_demux4 #(.W(4)) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .sof(sof),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .frame_vld(frame_vld), .sync_err(sync_err), .locked(locked),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame-level reference: a frame is whatever sequence of beats follows a marker.
    task automatic model_step(input bit r, input bit v, input bit s, input logic [3:0] d);
        m_fv = 0;
        m_se = 0;
        if (r) begin
            q.delete();
            m_lock = 0;
            m_cnt  = 0;
            for (int i = 0; i < 4; i++) m_ch[i] = '0;
        end else if (v) begin
            if (!m_lock) begin
                if (s) begin
                    q.delete();
                    q.push_back(d);
                    m_lock = 1;
                end
            end else if (s) begin
                if (q.size() != 0) m_se = 1;
                q.delete();
                q.push_back(d);
            end else if (q.size() == 0) begin
                m_se   = 1;
                m_lock = 0;
            end else begin
                q.push_back(d);
                if (q.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_ch[i] = q[i];
                    m_fv  = 1;
                    m_cnt = (m_cnt + 1) % 256;
                    q.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        chk("ch0", ch0, m_ch[0]);
        chk("ch1", ch1, m_ch[1]);
        chk("ch2", ch2, m_ch[2]);
        chk("ch3", ch3, m_ch[3]);
        chk("frame_vld", frame_vld, m_fv);
        chk("sync_err", sync_err, m_se);
        chk("locked", locked, m_lock);
        chk("frame_cnt", frame_cnt, m_cnt);
    endtask

    task automatic cyc(input bit r, input bit v, input bit s, input logic [3:0] d);
        rst = r; din_vld = v; sof = s; din = d;
        @(posedge clk);
        model_step(r, v, s, d);
        #1;
        if (frame_vld) fv_seen++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'($urandom));
    endtask

    task automatic beat(input bit s, input logic [3:0] d, input int maxgap);
        cyc(0, 1, s, d);
        if (maxgap > 0) idle($urandom_range(0, maxgap));
    endtask

    task automatic frame(input logic [3:0] a, b, c, d, input int maxgap);
        beat(1, a, maxgap);
        beat(0, b, maxgap);
        beat(0, c, maxgap);
        beat(0, d, maxgap);
    endtask

    initial begin
        rst = 1; din_vld = 0; sof = 0; din = '0;
        model_step(1, 0, 0, '0);
        cyc(1, 1, 1, 4'd7);
        cyc(1, 0, 0, 4'd0);
        chk("reset_locked", locked, 0);
        chk("reset_cnt", frame_cnt, 0);

        // Continuous frame 1,2,3,4
        frame(4'd1, 4'd2, 4'd3, 4'd4, 0);
        chk("tp1_ch0", ch0, 1);
        chk("tp1_ch3", ch3, 4);
        chk("tp1_fv", frame_vld, 1);
        chk("tp1_cnt", frame_cnt, 1);
        idle(1);
        chk("tp1_fv_pulse", frame_vld, 0);

        // Same frame with gaps
        for (int k = 0; k < 4; k++) frame(4'd1, 4'd2, 4'd3, 4'd4, 3);

        // Early marker on 3rd beat
        frame(4'hA, 4'hB, 4'hC, 4'hD, 0);
        beat(1, 4'd5, 1);
        beat(0, 4'd6, 1);
        beat(1, 4'd9, 0);
        chk("early_err", sync_err, 1);
        chk("early_ch0_kept", ch0, 4'hA);
        beat(0, 4'hA, 0);
        beat(0, 4'hB, 0);
        beat(0, 4'hC, 0);
        chk("early_new_ch0", ch0, 9);
        chk("early_new_ch3", ch3, 4'hC);

        // Missing marker at slot 0
        beat(0, 4'd3, 0);
        chk("miss_err", sync_err, 1);
        chk("miss_unlock", locked, 0);
        for (int k = 0; k < 5; k++) beat(0, 4'($urandom), 1);
        frame(4'd8, 4'd7, 4'd6, 4'd5, 1);
        chk("relock", locked, 1);

        // 256 back-to-back frames
        fv_seen = 0;
        for (int k = 0; k < 256; k++)
            frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 0);
        chk("b2b_fv_count", fv_seen, 256);

        // Reset mid-frame
        beat(1, 4'd1, 0);
        beat(0, 4'd2, 0);
        cyc(1, 0, 0, 4'd0);
        beat(0, 4'd3, 0);
        beat(0, 4'd4, 0);
        chk("rst_mid_ch0", ch0, 0);
        chk("rst_mid_locked", locked, 0);
        chk("rst_mid_cnt", frame_cnt, 0);

        // Random traffic
        for (int k = 0; k < 1500; k++)
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) == 0), 4'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
